// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared definitions for the 7-segment scan capture block.
//
// Contents:
//   glyph_e          5-bit glyph code produced by the pattern decoder
//   SEG_*            active-low a..g patterns (a = bit 6 .. g = bit 0 of the
//                    7-bit constant, matching abcdefgh[7:1] on the display bus)
//   N_DIGITS         number of multiplexed digits on the scanned display
package seg7_pkg;

    localparam int N_DIGITS = 4;

    typedef enum logic [4:0] {
        G_0       = 5'd0,
        G_1       = 5'd1,
        G_2       = 5'd2,
        G_3       = 5'd3,
        G_4       = 5'd4,
        G_5       = 5'd5,
        G_6       = 5'd6,
        G_7       = 5'd7,
        G_8       = 5'd8,
        G_9       = 5'd9,
        G_A       = 5'd10,
        G_B       = 5'd11,
        G_C       = 5'd12,
        G_K       = 5'd13,
        G_U       = 5'd14,
        G_BLANK   = 5'd15,
        G_UNKNOWN = 5'd16
    } glyph_e;

    // Segment patterns, active-low, bit order a..g.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_K     = 7'b0101000;
    localparam logic [6:0] SEG_U     = 7'b1000001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_glyph_decode.sv
// seg7_glyph_decode -- combinational segment-pattern to glyph decoder.
//
// Ports:
//   segs_i   [7:0]  captured abcdefgh byte (active-low); bit 0 (dp) is ignored
//   glyph_o  glyph_e decoded glyph; exact match on [7:1], else G_UNKNOWN
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [7:0] segs_i,
    output glyph_e     glyph_o
);

    always_comb begin
        glyph_o = G_UNKNOWN;
        case (segs_i[7:1])
            SEG_0:     glyph_o = G_0;
            SEG_1:     glyph_o = G_1;
            SEG_2:     glyph_o = G_2;
            SEG_3:     glyph_o = G_3;
            SEG_4:     glyph_o = G_4;
            SEG_5:     glyph_o = G_5;
            SEG_6:     glyph_o = G_6;
            SEG_7:     glyph_o = G_7;
            SEG_8:     glyph_o = G_8;
            SEG_9:     glyph_o = G_9;
            SEG_A:     glyph_o = G_A;
            SEG_B:     glyph_o = G_B;
            SEG_C:     glyph_o = G_C;
            SEG_K:     glyph_o = G_K;
            SEG_U:     glyph_o = G_U;
            SEG_BLANK: glyph_o = G_BLANK;
            default:   glyph_o = G_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture -- snoops a multiplexed 4-digit 7-segment display bus and
// rebuilds complete frames of what is being shown.
//
// Parameters:
//   STABLE_CYCLES  identical consecutive samples needed to accept a digit (2..255)
//   STALE_CYCLES   cycles without a capture before a digit is flagged stale
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   abcdefgh[7:0] segments, active-low, a = bit 7 .. g = bit 1, dp = bit 0
//   digit[3:0]   digit enables, active-low, one-hot-low selects digit i
//   glyphs[19:0] decoded glyph per digit, digit i at [5i+4:5i]
//   dp[3:0]      decimal point lit, per digit
//   segs[31:0]   raw captured abcdefgh per digit, digit i at [8i+7:8i]
//   frame_valid  one-cycle pulse when glyphs/dp/segs carry a new frame
//   stale[3:0]   per-digit "no capture within STALE_CYCLES"
//
// Build option: define SEG7_CAPTURE_STALE_EN to build the stale counters;
// without it stale is tied to zero.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STALE_CYCLES  = 2**24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  abcdefgh,
    input  logic [3:0]  digit,
    output logic [19:0] glyphs,
    output logic [3:0]  dp,
    output logic [31:0] segs,
    output logic        frame_valid,
    output logic [3:0]  stale
);

    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [19:0] GLYPHS_RST  = {4{G_BLANK}};

    // Two-flop synchronizers; the display bus is asynchronous to clk.
    logic [7:0] seg_meta_q, seg_sync_q;
    logic [3:0] dig_meta_q, dig_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_meta_q <= '0;
            seg_sync_q <= '0;
            dig_meta_q <= '0;
            dig_sync_q <= '0;
        end else begin
            seg_meta_q <= abcdefgh;
            seg_sync_q <= seg_meta_q;
            dig_meta_q <= digit;
            dig_sync_q <= dig_meta_q;
        end
    end

    // Candidate sample: exactly one digit enable low.
    logic       cand_valid;
    logic [1:0] cand_idx;

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = 2'd0;
        case (dig_sync_q)
            4'b1110: begin cand_valid = 1'b1; cand_idx = 2'd0; end
            4'b1101: begin cand_valid = 1'b1; cand_idx = 2'd1; end
            4'b1011: begin cand_valid = 1'b1; cand_idx = 2'd2; end
            4'b0111: begin cand_valid = 1'b1; cand_idx = 2'd3; end
            default: begin cand_valid = 1'b0; cand_idx = 2'd0; end
        endcase
    end

    // Stability tracking. cnt_q == 0 means "no valid previous sample", so a
    // candidate after an invalid sample always reloads to 1. dwell_q marks
    // that the current dwell has already been captured.
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] prev_idx_q;
    logic [7:0] prev_seg_q;
    logic       dwell_q, dwell_d;
    logic       same_sample;
    logic       capture;
    logic [3:0] cap_onehot;

    assign same_sample = (cnt_q != 8'd0) && (prev_idx_q == cand_idx) &&
                         (prev_seg_q == seg_sync_q);
    assign cap_onehot  = capture ? (4'b0001 << cand_idx) : 4'b0000;

    always_comb begin
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        capture = 1'b0;
        if (!cand_valid) begin
            cnt_d   = 8'd0;
            dwell_d = 1'b0;
        end else if (same_sample) begin
            if (cnt_q != STABLE_MAX) begin
                cnt_d = cnt_q + 8'd1;
            end
            // Capture on the sample that brings the count to STABLE_CYCLES.
            if ((cnt_q == STABLE_MAX - 8'd1) && !dwell_q) begin
                capture = 1'b1;
                dwell_d = 1'b1;
            end
        end else begin
            cnt_d   = 8'd1;
            dwell_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            dwell_q    <= 1'b0;
            prev_idx_q <= '0;
            prev_seg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            if (cand_valid) begin
                prev_idx_q <= cand_idx;
                prev_seg_q <= seg_sync_q;
            end
        end
    end

    // Slots, seen mask and frame assembly. frame_pend_q delays the publish by
    // one cycle so the last captured slot is already registered.
    logic [3:0][7:0] slot_q, slot_d;
    logic [3:0]      seen_q, seen_d;
    logic            frame_pend_q, frame_pend_d;

    always_comb begin
        slot_d = slot_q;
        if (capture) begin
            slot_d[cand_idx] = seg_sync_q;
        end
        // A publish cycle clears seen; a capture in that cycle starts the next frame.
        seen_d       = (frame_pend_q ? 4'b0000 : seen_q) | cap_onehot;
        frame_pend_d = capture && (seen_d == 4'b1111);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q       <= {4{8'hFF}};
            seen_q       <= '0;
            frame_pend_q <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            seen_q       <= seen_d;
            frame_pend_q <= frame_pend_d;
        end
    end

    // Decode every slot continuously; results are only latched on publish.
    glyph_e      slot_glyph [N_DIGITS];
    logic [19:0] slot_glyphs_packed;

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_dec
        seg7_glyph_decode u_dec (
            .segs_i  (slot_q[gi]),
            .glyph_o (slot_glyph[gi])
        );
    end

    always_comb begin
        slot_glyphs_packed = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            slot_glyphs_packed[5*i +: 5] = slot_glyph[i];
        end
    end

    logic [19:0] glyphs_q;
    logic [31:0] segs_q;
    logic        frame_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glyphs_q      <= GLYPHS_RST;
            segs_q        <= 32'hFFFF_FFFF;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= frame_pend_q;
            if (frame_pend_q) begin
                glyphs_q <= slot_glyphs_packed;
                segs_q   <= slot_q;
            end
        end
    end

    assign glyphs      = glyphs_q;
    assign segs        = segs_q;
    assign frame_valid = frame_valid_q;

    always_comb begin
        dp = 4'b0000;
        for (int i = 0; i < N_DIGITS; i++) begin
            dp[i] = ~segs_q[8*i];
        end
    end

`ifdef SEG7_CAPTURE_STALE_EN
    localparam int                STALE_W   = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

    logic [3:0][STALE_W-1:0] stale_cnt_q, stale_cnt_d;

    // Capture clears the counter, so it wins over saturation in the same cycle.
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (cap_onehot[i]) begin
                stale_cnt_d[i] = '0;
            end else if (stale_cnt_q[i] != STALE_MAX) begin
                stale_cnt_d[i] = stale_cnt_q[i] + STALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stale_cnt_q <= '0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
        end
    end

    always_comb begin
        stale = 4'b0000;
        for (int i = 0; i < N_DIGITS; i++) begin
            stale[i] = (stale_cnt_q[i] == STALE_MAX);
        end
    end
`else
    logic [31:0] unused_stale_cycles;
    assign unused_stale_cycles = 32'(STALE_CYCLES);
    assign stale = 4'b0000;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture -- directed bench for seg7_scan_capture.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_seg7_scan_capture;

    // Segment bytes (active-low abcdefgh, dp in bit 0, 1 = dp off).
    localparam logic [7:0] S_A      = 8'h11;
    localparam logic [7:0] S_U      = 8'h83;
    localparam logic [7:0] S_C      = 8'h63;
    localparam logic [7:0] S_ONE    = 8'h9F;
    localparam logic [7:0] S_TWO    = 8'h25;
    localparam logic [7:0] S_THREE  = 8'h0D;
    localparam logic [7:0] S_SEVEN  = 8'h1F;
    localparam logic [7:0] S_NINE   = 8'h09;
    localparam logic [7:0] S_JUNK   = 8'h55;
    localparam logic [7:0] S_FIVE_P = 8'h48;
    localparam logic [7:0] S_EIGHT_P = 8'h00;

    localparam logic [3:0] D0 = 4'b1110;
    localparam logic [3:0] D1 = 4'b1101;
    localparam logic [3:0] D2 = 4'b1011;
    localparam logic [3:0] D3 = 4'b0111;

    // Glyph codes.
    localparam logic [4:0] E_1 = 5'd1, E_2 = 5'd2, E_3 = 5'd3, E_5 = 5'd5;
    localparam logic [4:0] E_7 = 5'd7, E_8 = 5'd8, E_9 = 5'd9, E_A = 5'd10;
    localparam logic [4:0] E_C = 5'd12, E_U = 5'd14, E_BLANK = 5'd15, E_UNK = 5'd16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  abcdefgh;
    logic [3:0]  digit;
    logic [19:0] glyphs;
    logic [3:0]  dp;
    logic [31:0] segs;
    logic        frame_valid;
    logic [3:0]  stale;

    int n_checks = 0;
    int n_errors = 0;
    int frame_cnt = 0;
    int frames_before;
    logic [3:0] exp_stale_saturated;

    seg7_scan_capture #(
        .STABLE_CYCLES (4),
        .STALE_CYCLES  (100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .abcdefgh    (abcdefgh),
        .digit       (digit),
        .glyphs      (glyphs),
        .dp          (dp),
        .segs        (segs),
        .frame_valid (frame_valid),
        .stale       (stale)
    );

    // Clock / reset-independent frame counter.
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid) frame_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [3:0] d, input logic [7:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            digit    = d;
            abcdefgh = s;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        step(4'b1111, 8'hFF, n);
    endtask

    task automatic capture(input logic [3:0] d, input logic [7:0] s);
        step(d, s, 8);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);
    endtask

    initial begin
`ifdef SEG7_CAPTURE_STALE_EN
        exp_stale_saturated = 4'b0010;
`else
        exp_stale_saturated = 4'b0000;
`endif
        reset    = 1'b1;
        digit    = 4'b1111;
        abcdefgh = 8'hFF;
        @(negedge clk);
        do_reset();

        // Reset state.
        check("rst_glyphs", 32'(glyphs), 32'({4{E_BLANK}}));
        check("rst_dp", 32'(dp), 32'h0);
        check("rst_segs", segs, 32'hFFFF_FFFF);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);

        // Scan A,U,C,A on digits 3,2,1,0.
        capture(D3, S_A);
        capture(D2, S_U);
        capture(D1, S_C);
        capture(D0, S_A);
        idle(6);
        check("scan_frames", 32'(frame_cnt), 32'd1);
        check("scan_glyphs", 32'(glyphs), 32'({E_A, E_U, E_C, E_A}));
        check("scan_segs", segs, {S_A, S_U, S_C, S_A});
        check("scan_dp", 32'(dp), 32'h0);

        // Short dwell (3 samples) on digit 0 must not capture.
        frames_before = frame_cnt;
        step(D0, S_EIGHT_P, 3);
        capture(D1, S_ONE);
        capture(D2, S_JUNK);
        capture(D3, S_FIVE_P);
        idle(6);
        check("short_dwell_nofr", 32'(frame_cnt), 32'(frames_before));
        check("hold_glyphs", 32'(glyphs), 32'({E_A, E_U, E_C, E_A}));
        capture(D0, S_EIGHT_P);
        idle(6);
        check("dwell_frame", 32'(frame_cnt), 32'(frames_before + 1));
        check("dwell_glyphs", 32'(glyphs), 32'({E_5, E_UNK, E_1, E_8}));
        check("dwell_dp", 32'(dp), 32'b1001);
        check("dwell_segs", segs, {S_FIVE_P, S_JUNK, S_ONE, S_EIGHT_P});

        // Invalid digit patterns split a dwell; counter restarts afterwards.
        frames_before = frame_cnt;
        step(D0, S_TWO, 2);
        step(4'b0011, S_TWO, 20);
        step(D0, S_TWO, 1);
        step(4'b1111, S_TWO, 20);
        step(D0, S_TWO, 1);
        capture(D1, S_THREE);
        capture(D2, S_SEVEN);
        capture(D3, S_NINE);
        idle(6);
        check("invalid_nofr", 32'(frame_cnt), 32'(frames_before));
        capture(D0, S_TWO);
        idle(6);
        check("invalid_frame", 32'(frame_cnt), 32'(frames_before + 1));

        // Repeated capture of digit 0 overwrites without completing a frame.
        frames_before = frame_cnt;
        capture(D0, S_SEVEN);
        capture(D0, S_NINE);
        capture(D1, S_ONE);
        capture(D2, S_C);
        idle(6);
        check("repeat_nofr", 32'(frame_cnt), 32'(frames_before));
        capture(D3, S_U);
        idle(6);
        check("repeat_frame", 32'(frame_cnt), 32'(frames_before + 1));
        check("repeat_glyphs", 32'(glyphs), 32'({E_U, E_C, E_1, E_9}));

        // Reset after three captures discards the partial frame.
        capture(D0, S_THREE);
        capture(D1, S_TWO);
        capture(D2, S_SEVEN);
        do_reset();
        check("mid_rst_glyphs", 32'(glyphs), 32'({4{E_BLANK}}));
        check("mid_rst_segs", segs, 32'hFFFF_FFFF);
        check("mid_rst_dp", 32'(dp), 32'h0);
        check("mid_rst_fv", 32'(frame_valid), 32'h0);
        frames_before = frame_cnt;
        capture(D3, S_A);
        idle(6);
        check("post_rst_nofr", 32'(frame_cnt), 32'(frames_before));
        check("post_rst_blank", 32'(glyphs), 32'({4{E_BLANK}}));
        capture(D0, S_THREE);
        capture(D1, S_TWO);
        capture(D2, S_SEVEN);
        idle(6);
        check("post_rst_frame", 32'(frame_cnt), 32'(frames_before + 1));
        check("post_rst_glyphs", 32'(glyphs), 32'({E_A, E_7, E_2, E_3}));

        // Digit 1 never driven for >100 cycles after reset.
        do_reset();
        for (int r = 0; r < 5; r++) begin
            capture(D0, S_A);
            capture(D2, S_C);
            capture(D3, S_U);
        end
        check("stale_d1", 32'(stale), 32'(exp_stale_saturated));
        capture(D1, S_ONE);
        idle(4);
        check("stale_cleared", 32'(stale), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical samples needed to accept a digit (legal range 2..255).
REQ-002 SHALL have parameter STALE_CYCLES, default 2**24, the number of cycles without a capture after which a digit is flagged stale.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port abcdefgh  input  8  multiplexed segments, active-low, a=bit7 .. g=bit1, h (dp)=bit0.
REQ-006 SHALL have port digit  input  4  digit enables, active-low; one-hot-low selects digit index i.
REQ-007 SHALL have port glyphs  output  20  decoded glyph code per digit; digit i occupies [5i+4:5i].
REQ-008 SHALL have port dp  output  4  decimal point lit flag per digit.
REQ-009 SHALL have port segs  output  32  raw captured abcdefgh per digit; digit i occupies [8i+7:8i].
REQ-010 SHALL have port frame_valid  output  1  one-cycle pulse; glyphs, dp and segs hold a new complete frame.
REQ-011 SHALL have port stale  output  4  per-digit flag: no capture within STALE_CYCLES.

Function
REQ-012 SHALL pass abcdefgh and digit through a 2-flop synchronizer before any use.
REQ-013 SHALL treat a sample as a candidate only if exactly one digit bit is 0; zero-low or multi-low samples clear the stability counter and the dwell flag.
REQ-014 SHALL increment a saturating stability counter while the candidate (index, segments) equals the previous sample, and reload it to 1 on any change.
REQ-015 SHALL capture the candidate into the slot for its index on the cycle the counter reaches STABLE_CYCLES, exactly once per dwell; a further capture requires the candidate to change first.
REQ-016 SHALL set seen[i] on each capture; a repeated capture of an already seen digit overwrites its slot without completing a frame.
REQ-017 SHALL, on the cycle after the capture that makes seen all-ones, copy all slots to glyphs, dp and segs, pulse frame_valid for one cycle, and clear seen.
REQ-018 SHALL hold glyphs, dp and segs constant between frame_valid pulses.
REQ-019 SHALL decode by matching bits [7:1] exactly: 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=B, 0110001=C, 0101000=K, 1000001=U, 1111111=BLANK; any other pattern SHALL decode to UNKNOWN.
REQ-020 SHALL drive dp[i] = ~segs bit 0 of digit i.
REQ-021 SHALL give each digit a stale counter that is cleared on that digit's capture and saturates at STALE_CYCLES; stale[i] SHALL be 1 while the counter equals STALE_CYCLES.
REQ-022 SHALL, when a capture and a stale-counter saturation occur in the same cycle, give priority to the capture (stale[i] stays 0).

Reset
REQ-023 SHALL, on reset, clear the synchronizers, stability counter, dwell flag, seen, slots and stale counters, and drive glyphs = all BLANK, dp = 0, segs = all 8'hFF, frame_valid = 0, stale = 0.
REQ-024 SHALL, on reset asserted mid-dwell or mid-frame, discard the partial frame; the first frame after reset requires four new captures.

Configuration
REQ-025 SHALL implement stale counters and the stale output only when SEG7_CAPTURE_STALE_EN is defined; otherwise stale SHALL be tied to 4'b0000 and no stale counters SHALL exist.

Structure
REQ-026 SHALL take the glyph code enum (5-bit: G_0..G_9, G_A, G_B, G_C, G_K, G_U, G_BLANK, G_UNKNOWN) and the segment pattern constants from shared package seg7_pkg.
REQ-027 SHALL place the pattern-to-glyph decoder in combinational sub-module seg7_glyph_decode, instantiated once per slot.

Verification
REQ-028 SHALL cover: scan A,U,C,A (digit 0111,1011,1101,1110) at 8 cycles per digit -> one frame_valid; glyphs = G_A,G_C,G_U,G_A for digit 0..3 respectively (digit 3 = A, digit 0 = A).
REQ-029 SHALL cover: a dwell of STABLE_CYCLES-1 identical samples then a change -> no capture and seen unchanged.
REQ-030 SHALL cover: digit = 4'b0011 or 4'b1111 for 20 cycles -> no capture; stability counter stays cleared.
REQ-031 SHALL cover: segments 8'b01010101 on digit 2 -> glyph G_UNKNOWN and dp[2] = 0 in the next frame.
REQ-032 SHALL cover, with SEG7_CAPTURE_STALE_EN and STALE_CYCLES=100: digit 1 never driven -> stale = 4'b0010 after 100 cycles; driving digit 1 clears it.
REQ-033 SHALL cover: reset pulse after three captures -> outputs at reset values; no frame_valid until four fresh captures.
